// File: rtl/fifo_array_ctrl.sv
// fifo_array_ctrl
// Sequences a tile through a bank of ARRAY_SIZE FIFOs: clear the pointers,
// load ROW_LEN elements into each FIFO in row-major order, then drain all
// FIFOs with a wavefront read schedule.
//
// Build option:
//   FIFO_CTRL_SKEW_EN  defined   -> diagonal drain, FIFO i starts i cycles
//                                   after FIFO 0 (ROW_LEN+ARRAY_SIZE-1 cycles)
//                      undefined -> all FIFOs read together (ROW_LEN cycles)
module fifo_array_ctrl #(
  parameter int ARRAY_SIZE = 9,
  parameter int ROW_LEN    = 16,
  parameter int LOG_LEN    = 6
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic                  start,
  input  logic                  hold,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [ARRAY_SIZE-1:0] fifo_full,
  input  logic [ARRAY_SIZE-1:0] fifo_empty,
  output logic [ARRAY_SIZE-1:0] w_en,
  output logic [ARRAY_SIZE-1:0] r_en,
  output logic                  wclear,
  output logic                  rclear,
  output logic [ARRAY_SIZE-1:0] out_valid,
  output logic                  busy,
  output logic                  done,
  output logic                  err
);

  localparam logic [2:0] IDLE  = 3'd0;
  localparam logic [2:0] CLEAR = 3'd1;
  localparam logic [2:0] LOAD  = 3'd2;
  localparam logic [2:0] DRAIN = 3'd3;
  localparam logic [2:0] DONE  = 3'd4;

  localparam logic [LOG_LEN-1:0] CNT_ONE  = LOG_LEN'(1);
  localparam logic [LOG_LEN-1:0] ROW_LAST = LOG_LEN'(ROW_LEN - 1);
  localparam logic [LOG_LEN-1:0] COL_LAST = LOG_LEN'(ARRAY_SIZE - 1);

  // Last wavefront step: the diagonal schedule needs ARRAY_SIZE-1 extra
  // cycles so the last FIFO can finish its ROW_LEN reads.
`ifdef FIFO_CTRL_SKEW_EN
  localparam logic [LOG_LEN-1:0] T_LAST = LOG_LEN'(ROW_LEN + ARRAY_SIZE - 2);
`else
  localparam logic [LOG_LEN-1:0] T_LAST = LOG_LEN'(ROW_LEN - 1);
`endif

  logic [2:0]            state;
  logic [LOG_LEN-1:0]    elem_cnt;
  logic [LOG_LEN-1:0]    row_ptr;
  logic [LOG_LEN-1:0]    t_cnt;
  logic                  err_q;
  logic [ARRAY_SIZE-1:0] row_sel;
  logic [ARRAY_SIZE-1:0] sched;
  logic [ARRAY_SIZE-1:0] scheduled;
  logic                  accept;
  logic                  underflow;

  // Decode the FIFO currently being loaded into a one-hot select.
  always_comb begin
    row_sel = '0;
    for (int i = 0; i < ARRAY_SIZE; i++) begin
      row_sel[i] = (row_ptr == LOG_LEN'(i));
    end
  end

  // Load handshake: only the selected FIFO's full flag can stall upstream.
  always_comb begin
    in_ready = (state == LOAD) && ((fifo_full & row_sel) == '0);
    accept   = in_valid && in_ready;
    w_en     = accept ? row_sel : '0;
  end

`ifdef FIFO_CTRL_SKEW_EN
  // Diagonal window: FIFO i reads while t is in [i, i+ROW_LEN-1]; the borrow
  // bit of t-i marks t < i.
  always_comb begin
    logic [LOG_LEN:0] diff;
    sched = '0;
    diff  = '0;
    for (int i = 0; i < ARRAY_SIZE; i++) begin
      diff     = {1'b0, t_cnt} - (LOG_LEN + 1)'(i);
      sched[i] = !diff[LOG_LEN] && (diff[LOG_LEN-1:0] <= ROW_LAST);
    end
  end
`else
  // Flat window: every FIFO reads during the first ROW_LEN wavefront steps.
  always_comb begin
    sched = {ARRAY_SIZE{t_cnt <= ROW_LAST}};
  end
`endif

  // Read issue: stalls suppress all reads, empty FIFOs are masked and flagged.
  always_comb begin
    scheduled = ((state == DRAIN) && !hold) ? sched : '0;
    r_en      = scheduled & ~fifo_empty;
    underflow = |(scheduled & fifo_empty);
  end

  // Status outputs decoded straight from the state register.
  always_comb begin
    wclear = (state == CLEAR);
    rclear = (state == CLEAR);
    busy   = (state != IDLE);
    done   = (state == DONE);
    err    = err_q;
  end

  // Tile sequencer: state, load position and drain wavefront counter.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state    <= IDLE;
      elem_cnt <= '0;
      row_ptr  <= '0;
      t_cnt    <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            state <= CLEAR;
          end
        end
        CLEAR: begin
          elem_cnt <= '0;
          row_ptr  <= '0;
          t_cnt    <= '0;
          state    <= LOAD;
        end
        LOAD: begin
          if (accept) begin
            if (elem_cnt == ROW_LAST) begin
              elem_cnt <= '0;
              if (row_ptr == COL_LAST) begin
                row_ptr <= '0;
                t_cnt   <= '0;
                state   <= DRAIN;
              end else begin
                row_ptr <= row_ptr + CNT_ONE;
              end
            end else begin
              elem_cnt <= elem_cnt + CNT_ONE;
            end
          end
        end
        DRAIN: begin
          if (!hold) begin
            if (t_cnt == T_LAST) begin
              t_cnt <= '0;
              state <= DONE;
            end else begin
              t_cnt <= t_cnt + CNT_ONE;
            end
          end
        end
        DONE: begin
          state <= IDLE;
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

  // Sticky underflow flag; only a reset clears it.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      err_q <= 1'b0;
    end else if (underflow) begin
      err_q <= 1'b1;
    end
  end

  // Read data appears one cycle after r_en, so out_valid trails it by one.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      out_valid <= '0;
    end else begin
      out_valid <= r_en;
    end
  end

endmodule

// File: tb/tb_fifo_array_ctrl.sv
// tb_fifo_array_ctrl
// Directed bench for fifo_array_ctrl with ARRAY_SIZE=3, ROW_LEN=4.
// Expected drain schedules follow FIFO_CTRL_SKEW_EN.
module tb_fifo_array_ctrl;

  localparam int ARRAY_SIZE = 3;
  localparam int ROW_LEN    = 4;
  localparam int LOG_LEN    = 6;
`ifdef FIFO_CTRL_SKEW_EN
  localparam int DRAIN_LEN  = 6;
`else
  localparam int DRAIN_LEN  = 4;
`endif

  logic       clk        = 1'b0;
  logic       reset_n    = 1'b0;
  logic       start      = 1'b0;
  logic       hold       = 1'b0;
  logic       in_valid   = 1'b0;
  logic [2:0] fifo_full  = 3'b000;
  logic [2:0] fifo_empty = 3'b000;
  logic       in_ready;
  logic [2:0] w_en;
  logic [2:0] r_en;
  logic       wclear;
  logic       rclear;
  logic [2:0] out_valid;
  logic       busy;
  logic       done;
  logic       err;

  int         vec_count   = 0;
  int         miscompares = 0;
  int         accept_cnt  = 0;
  logic [2:0] prev_ren    = 3'b000;
  logic       exp_err     = 1'b0;

  fifo_array_ctrl #(
    .ARRAY_SIZE(ARRAY_SIZE),
    .ROW_LEN   (ROW_LEN),
    .LOG_LEN   (LOG_LEN)
  ) dut (
    .clk       (clk),
    .reset_n   (reset_n),
    .start     (start),
    .hold      (hold),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .fifo_full (fifo_full),
    .fifo_empty(fifo_empty),
    .w_en      (w_en),
    .r_en      (r_en),
    .wclear    (wclear),
    .rclear    (rclear),
    .out_valid (out_valid),
    .busy      (busy),
    .done      (done),
    .err       (err)
  );

  // Free-running clock, rising edges at 5, 15, 25, ...
  always #5 clk = ~clk;

  // Hand-written r_en pattern for each unstalled wavefront step.
  function automatic logic [2:0] exp_ren(input int t);
`ifdef FIFO_CTRL_SKEW_EN
    case (t)
      0:       return 3'b001;
      1:       return 3'b011;
      2:       return 3'b111;
      3:       return 3'b111;
      4:       return 3'b110;
      5:       return 3'b100;
      default: return 3'b000;
    endcase
`else
    case (t)
      0, 1, 2, 3: return 3'b111;
      default:    return 3'b000;
    endcase
`endif
  endfunction

  // Hand-written w_en for the k-th accepted element (row-major, 4 per FIFO).
  function automatic logic [2:0] exp_wen(input int k);
    if (k < 4) return 3'b001;
    else if (k < 8) return 3'b010;
    else return 3'b100;
  endfunction

  // Drive one cycle's inputs after the falling edge and let them settle.
  task automatic apply_stimulus(input logic st, input logic iv, input logic hd,
                                input logic [2:0] full, input logic [2:0] empty);
    @(negedge clk);
    start      = st;
    in_valid   = iv;
    hold       = hd;
    fifo_full  = full;
    fifo_empty = empty;
    #1;
  endtask

  // One comparison point.
  task automatic check_output(input string tag, input logic [14:0] observed,
                              input logic [14:0] expected);
    vec_count++;
    assert (observed === expected) else begin
      miscompares++;
      $error("[TB] FAIL %s: observed=%b expected=%b (rdy,wen,ren,ov,wclr,rclr,busy,done,err)",
             tag, observed, expected);
    end
  endtask

  // Check every output for the current cycle; out_valid must echo last r_en.
  task automatic check_step(input string tag, input logic rdy, input logic [2:0] wen,
                            input logic [2:0] ren, input logic clr, input logic bsy,
                            input logic dn);
    if (in_valid && in_ready) accept_cnt++;
    check_output(tag, {in_ready, w_en, r_en, out_valid, wclear, rclear, busy, done, err},
                 {rdy, wen, ren, prev_ren, clr, clr, bsy, dn, exp_err});
    prev_ren = ren;
  endtask

  // IDLE cycle with start, then the single CLEAR cycle.
  task automatic start_tile(input string name);
    apply_stimulus(1'b1, 1'b0, 1'b0, 3'b000, 3'b000);
    check_step({name, " idle"}, 1'b0, 3'b000, 3'b000, 1'b0, 1'b0, 1'b0);
    apply_stimulus(1'b0, 1'b0, 1'b0, 3'b000, 3'b000);
    check_step({name, " clear"}, 1'b0, 3'b000, 3'b000, 1'b1, 1'b1, 1'b0);
  endtask

  // Twelve back-to-back accepts with no backpressure.
  task automatic load_tile(input string name, input logic st);
    for (int k = 0; k < 12; k++) begin
      apply_stimulus(st, 1'b1, 1'b0, 3'b000, 3'b000);
      check_step({name, " load"}, 1'b1, exp_wen(k), 3'b000, 1'b0, 1'b1, 1'b0);
    end
  endtask

  // Unstalled drain steps t_from..t_to; upstream keeps offering data.
  task automatic drain_steps(input string name, input int t_from, input int t_to);
    for (int t = t_from; t <= t_to; t++) begin
      apply_stimulus(1'b0, 1'b1, 1'b0, 3'b000, 3'b000);
      check_step({name, " drain"}, 1'b0, 3'b000, exp_ren(t), 1'b0, 1'b1, 1'b0);
    end
  endtask

  // DONE pulse followed by the return to IDLE.
  task automatic finish_tile(input string name);
    apply_stimulus(1'b0, 1'b0, 1'b0, 3'b000, 3'b000);
    check_step({name, " done"}, 1'b0, 3'b000, 3'b000, 1'b0, 1'b1, 1'b1);
    apply_stimulus(1'b0, 1'b0, 1'b0, 3'b000, 3'b000);
    check_step({name, " back idle"}, 1'b0, 3'b000, 3'b000, 1'b0, 1'b0, 1'b0);
  endtask

  // Directed sequence: reset, basic, backpressure, hold, underflow, reset mid-drain.
  initial begin
    $display("[TB] fifo_array_ctrl directed test start");

    #2;
    check_output("reset state", {in_ready, w_en, r_en, out_valid, wclear, rclear, busy, done, err},
                 15'b0);

    @(negedge clk);
    reset_n = 1'b1;
    #1;
    check_step("after reset", 1'b0, 3'b000, 3'b000, 1'b0, 1'b0, 1'b0);

    // Basic tile; start held high through LOAD must be ignored.
    start_tile("basic");
    load_tile("basic", 1'b1);
    drain_steps("basic", 0, DRAIN_LEN - 1);
    finish_tile("basic");

    // Backpressure on FIFO 1 while the 6th element is offered.
    accept_cnt = 0;
    start_tile("bp");
    for (int k = 0; k < 5; k++) begin
      apply_stimulus(1'b0, 1'b1, 1'b0, 3'b000, 3'b000);
      check_step("bp load", 1'b1, exp_wen(k), 3'b000, 1'b0, 1'b1, 1'b0);
    end
    for (int s = 0; s < 2; s++) begin
      apply_stimulus(1'b0, 1'b1, 1'b0, 3'b010, 3'b000);
      check_step("bp stalled", 1'b0, 3'b000, 3'b000, 1'b0, 1'b1, 1'b0);
    end
    for (int k = 5; k < 12; k++) begin
      apply_stimulus(1'b0, 1'b1, 1'b0, 3'b000, 3'b000);
      check_step("bp load", 1'b1, exp_wen(k), 3'b000, 1'b0, 1'b1, 1'b0);
    end
    drain_steps("bp", 0, DRAIN_LEN - 1);
    check_output("bp accepts", 15'(accept_cnt), 15'd12);
    finish_tile("bp");

    // Hold for two cycles at t=2.
    start_tile("hold");
    load_tile("hold", 1'b0);
    drain_steps("hold", 0, 1);
    for (int s = 0; s < 2; s++) begin
      apply_stimulus(1'b0, 1'b0, 1'b1, 3'b000, 3'b000);
      check_step("hold stalled", 1'b0, 3'b000, 3'b000, 1'b0, 1'b1, 1'b0);
    end
    drain_steps("hold", 2, DRAIN_LEN - 1);
    finish_tile("hold");

    // Underflow on FIFO 2 at t=3.
    start_tile("uflow");
    load_tile("uflow", 1'b0);
    drain_steps("uflow", 0, 2);
    apply_stimulus(1'b0, 1'b0, 1'b0, 3'b000, 3'b100);
    check_step("uflow t3", 1'b0, 3'b000, exp_ren(3) & 3'b011, 1'b0, 1'b1, 1'b0);
    exp_err = 1'b1;
    drain_steps("uflow", 4, DRAIN_LEN - 1);
    finish_tile("uflow");

    // Reset in the middle of DRAIN; err is still set going in.
    start_tile("rst");
    load_tile("rst", 1'b0);
    drain_steps("rst", 0, 2);
    apply_stimulus(1'b0, 1'b0, 1'b0, 3'b000, 3'b000);
    check_step("rst t3", 1'b0, 3'b000, exp_ren(3), 1'b0, 1'b1, 1'b0);
    reset_n = 1'b0;
    #1;
    check_output("async reset", {in_ready, w_en, r_en, out_valid, wclear, rclear, busy, done, err},
                 15'b0);
    @(posedge clk);
    #1;
    check_output("held reset", {in_ready, w_en, r_en, out_valid, wclear, rclear, busy, done, err},
                 15'b0);
    prev_ren = 3'b000;
    exp_err  = 1'b0;

    // Release reset with start already high: the first rising edge takes it.
    @(negedge clk);
    reset_n = 1'b1;
    start   = 1'b1;
    #1;
    check_step("post rst idle", 1'b0, 3'b000, 3'b000, 1'b0, 1'b0, 1'b0);
    apply_stimulus(1'b0, 1'b0, 1'b0, 3'b000, 3'b000);
    check_step("post rst clear", 1'b0, 3'b000, 3'b000, 1'b1, 1'b1, 1'b0);
    load_tile("post rst", 1'b0);
    drain_steps("post rst", 0, DRAIN_LEN - 1);
    finish_tile("post rst");

    $display("== %0d vectors applied, %0d miscompares ==", vec_count, miscompares);
    $finish;
  end

endmodule
